// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
`timescale 1ns/1ps
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer: byte-lane steering, load extension and PC stall.
// Optional LSU_MISALIGN_SPLIT_EN: misaligned accesses are split instead of trapped.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_enb,
  input  logic              store_enb,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              lsu_stall,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              misalign_trap,
  load_store_unit_if.master mem
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SECOND, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be, r_be_hi;
  logic [31:0]       r_mem_wdata, r_beat0, r_load_data;
  logic              r_we, r_split, r_trap, r_is_load;
  logic [1:0]        r_off;
  logic [2:0]        r_f3;

  logic              w_req, w_f3_ok, w_trap, w_split, w_mem_req, w_last_beat;
  logic [1:0]        w_off;
  logic [3:0]        w_be_base;
  logic [7:0]        w_be8;
  logic [31:0]       w_repl, w_wdata, w_lo, w_hi, w_word, w_ext;

  assign w_req = load_enb | store_enb;
  assign w_off = addr[1:0];

  // Loads accept 000,001,010,100,101; stores only 000,001,010.
  assign w_f3_ok = store_enb ? (~funct3[2] & (funct3[1:0] != 2'b11))
                             : ((funct3[1:0] != 2'b11) & ~(funct3[2] & funct3[1]));

`ifdef LSU_MISALIGN_SPLIT_EN
  assign w_trap  = (load_enb & store_enb) | ~w_f3_ok;
  assign w_split = ((funct3[1:0] == 2'b01) & (w_off == 2'd3)) |
                   ((funct3[1:0] == 2'b10) & (w_off != 2'd0));
`else
  assign w_trap  = (load_enb & store_enb) | ~w_f3_ok |
                   ((funct3[1:0] == 2'b01) & w_off[0]) |
                   ((funct3[1:0] == 2'b10) & (w_off != 2'd0));
  assign w_split = 1'b0;
`endif

  always_comb begin
    case (funct3[1:0])
      2'b00:   begin w_be_base = 4'b0001; w_repl = {4{store_data[7:0]}};  end
      2'b01:   begin w_be_base = 4'b0011; w_repl = {2{store_data[15:0]}}; end
      default: begin w_be_base = 4'b1111; w_repl = store_data;            end
    endcase
  end

  // Upper nibble holds the enables for the second beat of a word-crossing access.
  assign w_be8 = {4'b0000, w_be_base} << w_off;

  // Rotating the replicated pattern puts every byte on its own lane for both beats.
  always_comb begin
    w_wdata = '0;
    for (int unsigned i = 0; i < 4; i++)
      w_wdata[8*i +: 8] = w_repl[8*((i + 4 - 32'(w_off)) % 4) +: 8];
  end

  assign w_lo = (r_state == S_SECOND) ? r_beat0 : mem.mem_rdata;
  assign w_hi = mem.mem_rdata;

  always_comb begin
    w_word = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i + 32'(r_off) >= 4)
        w_word[8*i +: 8] = w_hi[8*(i + 32'(r_off) - 4) +: 8];
      else
        w_word[8*i +: 8] = w_lo[8*(i + 32'(r_off)) +: 8];
    end
  end

  always_comb begin
    case (r_f3[1:0])
      2'b00:   w_ext = {{24{~r_f3[2] & w_word[7]}},  w_word[7:0]};
      2'b01:   w_ext = {{16{~r_f3[2] & w_word[15]}}, w_word[15:0]};
      default: w_ext = w_word;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    lsu_stall     = 1'b0;
    w_mem_req     = 1'b0;
    load_valid    = 1'b0;
    misalign_trap = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          lsu_stall = 1'b1;
          w_next    = w_trap ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        lsu_stall = 1'b1;
        w_mem_req = 1'b1;
        if (mem.mem_ready) w_next = r_split ? S_SECOND : S_DONE;
      end
      S_SECOND: begin
        lsu_stall = 1'b1;
        w_mem_req = 1'b1;
        if (mem.mem_ready) w_next = S_DONE;
      end
      default: begin
        w_next        = S_IDLE;
        load_valid    = r_is_load & ~r_trap;
        misalign_trap = r_trap;
      end
    endcase
    // Stall must drop with reset even while a command is still presented.
    if (!reset) lsu_stall = 1'b0;
  end

  assign w_last_beat = mem.mem_ready &
                       (((r_state == S_ACCESS) & ~r_split) | (r_state == S_SECOND));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_be_hi     <= '0;
      r_mem_wdata <= '0;
      r_beat0     <= '0;
      r_load_data <= '0;
      r_we        <= 1'b0;
      r_split     <= 1'b0;
      r_trap      <= 1'b0;
      r_is_load   <= 1'b0;
      r_off       <= '0;
      r_f3        <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_req) begin
        r_trap    <= w_trap;
        r_is_load <= load_enb;
        if (!w_trap) begin
          r_mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
          r_mem_be    <= w_be8[3:0];
          r_be_hi     <= w_be8[7:4];
          r_mem_wdata <= w_wdata;
          r_we        <= store_enb;
          r_off       <= w_off;
          r_f3        <= funct3;
          r_split     <= w_split;
        end
      end
      if ((r_state == S_ACCESS) && mem.mem_ready && r_split) begin
        r_beat0    <= mem.mem_rdata;
        r_mem_addr <= r_mem_addr + ADDR_W'(4);
        r_mem_be   <= r_be_hi;
      end
      if (w_last_beat && r_is_load)
        r_load_data <= w_ext;
    end
  end

  assign mem.mem_req   = w_mem_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_be    = r_mem_be;
  assign mem.mem_wdata = r_mem_wdata;
  assign load_data     = r_load_data;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequences data-memory accesses for load and store instructions between the datapath's ALU output and the data memory. It takes the effective address, store data and funct3, and drives a request/ready handshake with byte enables. It sign/zero-extends load results for the writeback mux and stalls the program counter (`pc_write = ~lsu_stall`) until the access completes.

## Interface
- `ADDR_W`, 32, address width; effective address from ALU.
- `DATA_W`, 32, data width; fixed at 32, byte lanes = 4.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `load_enb`  in  1  load instruction in flight, from control unit.
- `store_enb`  in  1  store instruction in flight, from control unit.
- `funct3`  in  3  instruction[14:12], access size/signedness.
- `addr`  in  ADDR_W  effective address (ALU output).
- `store_data`  in  32  rs2 value.
- `lsu_stall`  out  1  high while PC must hold.
- `load_data`  out  32  extended load result, held until the next load completes.
- `load_valid`  out  1  one-cycle pulse, `load_data` updated.
- `misalign_trap`  out  1  one-cycle pulse, access rejected.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  ADDR_W  word-aligned address (`[1:0]=0`).
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-aligned write data.
- `mem_ready`  in  1  beat accepted/completed this edge.
- `mem_rdata`  in  32  read data, valid when `mem_ready`.

## Operation
- FSM states: IDLE, ACCESS, SECOND, DONE.
- IDLE → ACCESS when `load_enb|store_enb` and the access is legal.
- IDLE → DONE with a trap when the access is illegal or misaligned.
- ACCESS → DONE on `mem_ready`, or → SECOND on `mem_ready` when split (see Configuration).
- SECOND → DONE on `mem_ready`.
- DONE → IDLE unconditionally.
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: 000 SB, 001 SH, 010 SW.
- Any other funct3, or `load_enb&store_enb`, is illegal → trap, no `mem_req`.
- Byte lanes: SB gives `mem_be = 4'b0001<<addr[1:0]`, with the data byte replicated on all lanes. SH gives `4'b0011<<addr[1:0]`, with the halfword replicated. SW gives `4'b1111`.
- Load extraction: select the byte or halfword at `addr[1:0]`. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Command fields (addr, funct3, data, type) are registered on IDLE→ACCESS. Inputs are ignored outside IDLE.

## Timing
- Reset (async): state IDLE; `lsu_stall`, `load_valid`, `misalign_trap`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_be`, `mem_wdata`, `load_data` = 0.
- `lsu_stall` is high combinationally in IDLE when `load_enb|store_enb`, and in ACCESS and SECOND. It is low in DONE, so the PC advances at the DONE edge.
- `mem_req` is high exactly in ACCESS and SECOND. `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` stay stable while `mem_req` is high and `mem_ready` is low.
- `mem_ready` while `mem_req` is low is ignored.
- Zero-wait memory gives 3 cycles per access: detect (IDLE), request (ACCESS), DONE. Each wait cycle adds 1.
- `load_valid` and `misalign_trap` are asserted only in DONE, and never both.
- Stores never pulse `load_valid`.
- Reset mid-access drops `mem_req` immediately and abandons the beat.

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined:
  - A misaligned access within one word (LH/SH at offset 1) takes one beat with shifted enables (`4'b0110`).
  - A word-crossing access (half at offset 3, word at offset 1–3) takes two beats. The first beat goes to `addr&~3`. The second goes to `(addr&~3)+4`, wrapping modulo 2^32.
  - Load bytes from both beats are assembled before extension. No trap for misalignment.
- Undefined: SECOND is unreachable. LH/LHU/SH with `addr[0]=1`, or LW/SW with `addr[1:0]≠0`, → `misalign_trap`, with no memory access.

## Test plan
- LW `addr=0x100`, `mem_rdata=0xDEADBEEF`, ready 1st cycle → `load_data=0xDEADBEEF`, `load_valid` in cycle 2, `lsu_stall` high for cycles 0–1.
- LB `addr=0x103`, `mem_rdata=0x80xxxxxx` → `load_data=0xFFFFFF80`; LBU → `0x00000080`.
- SH `addr=0x202`, `store_data=0x1234ABCD`, ready held low 3 cycles → `mem_be=4'b1100`, `mem_wdata=0xABCDABCD`, stable for 4 cycles; DONE after ready.
- LW `addr=0x101`:
  - Without the macro → `misalign_trap` pulse, no `mem_req`.
  - With the macro → beats to `0x100` then `0x104`. Rdata `0x44332211`/`0x88776655` → `0x55443322`.
- Assert `reset`=0 during ACCESS → `mem_req` and `lsu_stall` fall asynchronously; after release the FSM is in IDLE and a new LW completes normally.
